// File: rtl/pesagem_filtro.sv
// Load-cell acquisition: window averaging, tare offset, clamp to 12-bit grams.
// Produces overload/negative/stability flags for the display logic.
module pesagem_filtro #(
  parameter int K   = 2,
  parameter int TOL = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] amostra,
  input  logic        amostra_valida,
  input  logic        tara,
  input  logic        segurar,
  output logic [11:0] gramas,
  output logic        gramas_valida,
  output logic        sobrecarga,
  output logic        negativo,
  output logic        estavel
);

  localparam int AW = 16 + K;
  localparam int CW = (K > 0) ? K : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << K) - 1);
  localparam logic [11:0] TOL_W = 12'(TOL);

  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   tara_q, tara_d;
  logic          pend_q, pend_d;
  logic [11:0]   prev_q, prev_d;
  logic [11:0]   gramas_q, gramas_d;
  logic          vld_q, vld_d;
  logic          ov_q, ov_d;
  logic          neg_q, neg_d;
  logic          est_q, est_d;

  logic [AW-1:0]      soma;
  logic [15:0]        media;
  logic               fim;
  logic               captura;
  logic signed [16:0] liq;
  logic               liq_neg;
  logic               liq_ov;
  logic [11:0]        cl;
  logic [11:0]        dif;

  always_comb begin
    soma    = acc_q + AW'(amostra);
    media   = soma[K +: 16];
    fim     = amostra_valida && (cnt_q == CNT_LAST);
    captura = fim && (pend_q || tara);
    // a capturing window measures against itself, so its net is zero
    if (captura) liq = '0;
    else liq = $signed({1'b0, media}) - $signed({1'b0, tara_q});
    liq_neg = liq[16];
    liq_ov  = !liq_neg && (liq[15:12] != 4'd0);
    if (liq_neg)     cl = 12'd0;
    else if (liq_ov) cl = 12'hFFF;
    else             cl = liq[11:0];
    dif = (cl >= prev_q) ? (cl - prev_q) : (prev_q - cl);

    acc_d    = acc_q;
    cnt_d    = cnt_q;
    tara_d   = tara_q;
    pend_d   = pend_q | tara;
    prev_d   = prev_q;
    gramas_d = gramas_q;
    vld_d    = 1'b0;
    ov_d     = ov_q;
    neg_d    = neg_q;
    est_d    = est_q;

    if (amostra_valida) begin
      if (fim) begin
        acc_d  = '0;
        cnt_d  = '0;
        prev_d = cl;
        if (captura) begin
          tara_d = media;
          pend_d = 1'b0;
        end
        if (!segurar) begin
          gramas_d = cl;
          vld_d    = 1'b1;
          ov_d     = liq_ov;
          neg_d    = liq_neg;
          est_d    = (dif <= TOL_W);
        end
      end else begin
        acc_d = soma;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      tara_q   <= '0;
      pend_q   <= 1'b0;
      prev_q   <= '0;
      gramas_q <= '0;
      vld_q    <= 1'b0;
      ov_q     <= 1'b0;
      neg_q    <= 1'b0;
      est_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      tara_q   <= tara_d;
      pend_q   <= pend_d;
      prev_q   <= prev_d;
      gramas_q <= gramas_d;
      vld_q    <= vld_d;
      ov_q     <= ov_d;
      neg_q    <= neg_d;
      est_q    <= est_d;
    end
  end

  assign gramas        = gramas_q;
  assign gramas_valida = vld_q;
  assign sobrecarga    = ov_q;
  assign negativo      = neg_q;
  assign estavel       = est_q;

endmodule

// File: tb/tb_pesagem_filtro.sv
// Directed bench for pesagem_filtro with a window-level reference model.
// Outputs are checked every cycle at the falling edge.
module tb_pesagem_filtro;
  localparam int K   = 2;
  localparam int TOL = 2;
  localparam int N   = 1 << K;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] amostra = '0;
  logic        amostra_valida = 1'b0;
  logic        tara = 1'b0;
  logic        segurar = 1'b0;
  logic [11:0] gramas;
  logic        gramas_valida;
  logic        sobrecarga;
  logic        negativo;
  logic        estavel;

  pesagem_filtro #(.K(K), .TOL(TOL)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .amostra(amostra),
    .amostra_valida(amostra_valida),
    .tara(tara),
    .segurar(segurar),
    .gramas(gramas),
    .gramas_valida(gramas_valida),
    .sobrecarga(sobrecarga),
    .negativo(negativo),
    .estavel(estavel)
  );

  always #5 clk = ~clk;

  int win[$];
  int m_tare, m_prev;
  bit m_pend;
  int e_g;
  bit e_v, e_ov, e_neg, e_st;
  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic lit(string nm, int act, int mdl, int want);
    chk(nm, act, want);
    chk({nm, "_model"}, mdl, want);
  endtask

  task automatic m_reset();
    win.delete();
    m_tare = 0; m_prev = 0; m_pend = 0;
    e_g = 0; e_v = 0; e_ov = 0; e_neg = 0; e_st = 0;
  endtask

  // Window-level model: collect samples, average when the window is full.
  task automatic model(bit v, int s, bit t, bit h);
    int sum, avg, net, cl, d;
    e_v = 0;
    if (t) m_pend = 1;
    if (v) begin
      win.push_back(s);
      if (win.size() == N) begin
        sum = 0;
        foreach (win[i]) sum += win[i];
        avg = sum / N;
        if (m_pend) begin
          m_tare = avg; m_pend = 0; net = 0;
        end else begin
          net = avg - m_tare;
        end
        cl = (net < 0) ? 0 : (net > 4095) ? 4095 : net;
        d = (cl > m_prev) ? cl - m_prev : m_prev - cl;
        m_prev = cl;
        if (!h) begin
          e_g = cl; e_v = 1;
          e_ov = (net > 4095); e_neg = (net < 0); e_st = (d <= TOL);
        end
        win.delete();
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("gramas", int'(gramas), e_g);
      chk("gramas_valida", int'(gramas_valida), int'(e_v));
      chk("sobrecarga", int'(sobrecarga), int'(e_ov));
      chk("negativo", int'(negativo), int'(e_neg));
      chk("estavel", int'(estavel), int'(e_st));
    end
  end

  task automatic step(bit v, int s, bit t, bit h);
    amostra = 16'(s); amostra_valida = v; tara = t; segurar = h;
    @(posedge clk);
    model(v, s, t, h);
    #1;
    amostra_valida = 0; tara = 0;
  endtask

  task automatic window(int val, bit t_first, bit h);
    for (int i = 0; i < N; i++) step(1, val, t_first && (i == 0), h);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    m_reset();
    do_reset();
    #1;
    lit("rst_gramas", int'(gramas), e_g, 0);
    lit("rst_valida", int'(gramas_valida), int'(e_v), 0);
    lit("rst_estavel", int'(estavel), int'(e_st), 0);
    chk_en = 1;

    window(500, 0, 0);
    lit("w500", int'(gramas), e_g, 500);
    lit("w500_valida", int'(gramas_valida), int'(e_v), 1);
    step(0, 0, 0, 0);
    lit("w500_pulse_end", int'(gramas_valida), int'(e_v), 0);

    step(1, 100, 0, 0); step(1, 200, 0, 0);
    step(1, 300, 0, 0); step(1, 401, 0, 0);
    lit("trunc", int'(gramas), e_g, 250);

    window(300, 1, 0);
    lit("tare_zero", int'(gramas), e_g, 0);
    window(800, 0, 0);
    lit("tare_800", int'(gramas), e_g, 500);
    window(200, 0, 0);
    lit("tare_neg_g", int'(gramas), e_g, 0);
    lit("tare_neg_f", int'(negativo), int'(e_neg), 1);

    step(1, 60, 0, 0); step(1, 60, 0, 0);
    step(1, 60, 0, 0); step(1, 60, 1, 0);
    lit("tare_same_cycle", int'(gramas), e_g, 0);
    window(70, 0, 0);
    lit("tare_same_next", int'(gramas), e_g, 10);

    do_reset();
    window(5000, 0, 0);
    lit("ovl_g", int'(gramas), e_g, 4095);
    lit("ovl_f", int'(sobrecarga), int'(e_ov), 1);
    window(1000, 0, 0);
    lit("w1000", int'(gramas), e_g, 1000);
    lit("w1000_ov", int'(sobrecarga), int'(e_ov), 0);
    lit("w1000_st", int'(estavel), int'(e_st), 0);
    window(1002, 0, 0);
    lit("w1002_st", int'(estavel), int'(e_st), 1);
    window(1003, 0, 0);
    lit("w1003_st", int'(estavel), int'(e_st), 1);
    window(1010, 0, 0);
    lit("w1010_st", int'(estavel), int'(e_st), 0);

    window(700, 0, 1);
    lit("hold_g", int'(gramas), e_g, 1010);
    lit("hold_v", int'(gramas_valida), int'(e_v), 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    window(900, 0, 0);
    lit("rel_g", int'(gramas), e_g, 900);
    lit("rel_v", int'(gramas_valida), int'(e_v), 1);
    lit("rel_st", int'(estavel), int'(e_st), 0);

    step(1, 4000, 0, 0);
    step(1, 4000, 0, 0);
    #2;
    rst_n = 0;
    m_reset();
    #1;
    lit("arst_g", int'(gramas), e_g, 0);
    lit("arst_ov", int'(sobrecarga), int'(e_ov), 0);
    lit("arst_neg", int'(negativo), int'(e_neg), 0);
    lit("arst_st", int'(estavel), int'(e_st), 0);
    lit("arst_v", int'(gramas_valida), int'(e_v), 0);
    @(negedge clk);
    rst_n = 1;
    window(10, 0, 0);
    lit("post_rst", int'(gramas), e_g, 10);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
